// File: rtl/pc_ctrl_ras_pkg.sv
// Shared definitions for the PC unit: jump kinds, link registers and the default reset PC.
package pc_ctrl_ras_pkg;

  typedef enum logic [1:0] {
    JK_JAL    = 2'b00,
    JK_JALR   = 2'b01,
    JK_BRANCH = 2'b10,
    JK_SEQ    = 2'b11
  } jump_kind_e;

  localparam logic [4:0]  LINK_RA          = 5'd1;
  localparam logic [4:0]  LINK_T0          = 5'd5;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h8000_0000;

  function automatic logic is_link(input logic [4:0] r);
    return (r == LINK_RA) || (r == LINK_T0);
  endfunction

endpackage

// File: rtl/pc_ctrl_ras_stack.sv
// Circular return-address stack; a push while full silently overwrites the oldest entry.
// push+pop together replaces the top entry; on an empty stack it behaves as a plain push.
module ras_stack #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 8,
  localparam int PW    = $clog2(DEPTH),
  localparam int DW    = PW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] push_data_i,
  output logic [WIDTH-1:0] top_data_o,
  output logic [DW-1:0]    depth_o,
  output logic             full_o,
  output logic             empty_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    top_q, top_d, wr_ptr;
  logic [DW-1:0]    depth_q, depth_d;
  logic             wr_en;

  assign empty_o    = (depth_q == '0);
  assign full_o     = (depth_q == DW'(DEPTH));
  assign depth_o    = depth_q;
  assign top_data_o = mem_q[top_q];

  always_comb begin
    top_d   = top_q;
    depth_d = depth_q;
    wr_en   = 1'b0;
    wr_ptr  = top_q + PW'(1);
    if (push_i && pop_i && !empty_o) begin
      wr_en  = 1'b1;
      wr_ptr = top_q;
    end else if (push_i) begin
      wr_en = 1'b1;
      top_d = top_q + PW'(1);
      if (!full_o) depth_d = depth_q + DW'(1);
    end else if (pop_i && !empty_o) begin
      top_d   = top_q - PW'(1);
      depth_d = depth_q - DW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      top_q   <= '0;
      depth_q <= '0;
    end else begin
      top_q   <= top_d;
      depth_q <= depth_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr] <= push_data_i;
  end

endmodule

// File: rtl/pc_ctrl_ras.sv
// Program counter with next-PC selection, call/return classification and a checked return-address stack.
// Call/return events, mismatch and misalignment are registered one cycle after the committing instruction.
module pc_ctrl_ras
  import pc_ctrl_ras_pkg::*;
#(
  parameter  int                    ADDR_WIDTH = 32,
  parameter  logic [ADDR_WIDTH-1:0] RESET_PC   = ADDR_WIDTH'(DEFAULT_RESET_PC),
  parameter  int                    INST_BYTES = 4,
  parameter  int                    RAS_DEPTH  = 8,
  localparam int                    DEPTH_W    = $clog2(RAS_DEPTH) + 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  advance_i,
  input  logic [31:0]           instruction_i,
  input  logic [1:0]            jump_kind_i,
  input  logic [ADDR_WIDTH-1:0] offset_i,
  input  logic [ADDR_WIDTH-1:0] src1_i,
  input  logic                  branch_taken_i,
  output logic [ADDR_WIDTH-1:0] pc_o,
  output logic [ADDR_WIDTH-1:0] npc_o,
  output logic                  ev_call_o,
  output logic                  ev_ret_o,
  output logic [ADDR_WIDTH-1:0] ev_pc_o,
  output logic [ADDR_WIDTH-1:0] ev_target_o,
  output logic                  ret_mismatch_o,
  output logic                  misalign_o,
  output logic [DEPTH_W-1:0]    depth_o,
  output logic                  overflow_sticky_o,
  output logic                  underflow_sticky_o
);

  localparam logic [ADDR_WIDTH-1:0] INC = ADDR_WIDTH'(INST_BYTES);

  jump_kind_e            kind;
  logic [4:0]            rd, rs1;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, seq_pc, rel_pc, jalr_sum, target;
  logic [ADDR_WIDTH-1:0] ev_pc_q, ev_target_q, ras_top;
  logic                  is_call, is_ret, ras_full, ras_empty;
  logic                  ev_call_q, ev_ret_q, ret_mismatch_q, misalign_q;
  logic                  overflow_q, underflow_q;
  logic                  unused_instr_bits;

  assign kind              = jump_kind_e'(jump_kind_i);
  assign rd                = instruction_i[11:7];
  assign rs1               = instruction_i[19:15];
  assign unused_instr_bits = ^{instruction_i[31:20], instruction_i[14:12], instruction_i[6:0]};

  assign seq_pc   = pc_q + INC;
  assign rel_pc   = pc_q + offset_i;
  assign jalr_sum = src1_i + offset_i;

  always_comb begin
    target = seq_pc;
    case (kind)
      JK_JAL:    target = rel_pc;
      JK_JALR:   target = {jalr_sum[ADDR_WIDTH-1:1], 1'b0};
      JK_BRANCH: target = branch_taken_i ? rel_pc : seq_pc;
      default:   target = seq_pc;
    endcase
  end

  assign pc_d  = advance_i ? target : pc_q;
  assign npc_o = pc_d;

  // A jalr linking through both rd and rs1 is a coroutine swap: it is both a call and a return.
  assign is_call = ((kind == JK_JAL) || (kind == JK_JALR)) && is_link(rd);
  assign is_ret  = (kind == JK_JALR) && is_link(rs1) && ((rd == 5'd0) || is_link(rd));

  ras_stack #(
    .WIDTH (ADDR_WIDTH),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (advance_i && is_call),
    .pop_i       (advance_i && is_ret),
    .push_data_i (seq_pc),
    .top_data_o  (ras_top),
    .depth_o     (depth_o),
    .full_o      (ras_full),
    .empty_o     (ras_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pc_q           <= RESET_PC;
      ev_call_q      <= 1'b0;
      ev_ret_q       <= 1'b0;
      ret_mismatch_q <= 1'b0;
      misalign_q     <= 1'b0;
      ev_pc_q        <= '0;
      ev_target_q    <= '0;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      ev_call_q      <= advance_i && is_call;
      ev_ret_q       <= advance_i && is_ret;
      ret_mismatch_q <= advance_i && is_ret && (ras_empty || (ras_top != target));
      misalign_q     <= advance_i && target[1];
      if (advance_i && (is_call || is_ret)) begin
        ev_pc_q     <= pc_q;
        ev_target_q <= target;
      end
      if (advance_i && is_call && !is_ret && ras_full) overflow_q  <= 1'b1;
      if (advance_i && is_ret && ras_empty)            underflow_q <= 1'b1;
    end
  end

  assign pc_o               = pc_q;
  assign ev_call_o          = ev_call_q;
  assign ev_ret_o           = ev_ret_q;
  assign ev_pc_o            = ev_pc_q;
  assign ev_target_o        = ev_target_q;
  assign ret_mismatch_o     = ret_mismatch_q;
  assign misalign_o         = misalign_q;
  assign overflow_sticky_o  = overflow_q;
  assign underflow_sticky_o = underflow_q;

endmodule
